ctrl_mem_sequencer: RTL

Per-tile control-memory sequencer for the CGRA crossbar. It stores up to `DEPTH` crossbar configuration words (`CGRAConfig_6_4_6_8`), loaded from the configuration bus. On `start` it replays them in order into the crossbar's `recv_opt` handshake, looping a programmable number of times. When not running it drives an `OPT_START` (all-zero) word, so the crossbar forwards nothing.

---
 rtl/cgra_pkg.sv | 22 ++
 rtl/ctrl_mem_rf.sv | 25 ++
 rtl/ctrl_mem_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA types: crossbar configuration word, opcode constants and the
// control-memory sequencer state encoding.
package cgra_pkg;

  localparam logic [5:0] OPT_START = 6'd0;

  // 6 + 1 + 6 + 4*3 + 8*3 = 49 bits
  typedef struct packed {
    logic [5:0]      ctrl;
    logic            predicate;
    logic [5:0]      predicate_in;
    logic [3:0][2:0] fu_in;
    logic [7:0][2:0] routing_xbar_outport;
  } CGRAConfig_6_4_6_8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/ctrl_mem_rf.sv
// Control-memory storage: DEPTH configuration words, one synchronous write
// port and one combinational read port. Contents survive reset.
module ctrl_mem_rf
  import cgra_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  CGRAConfig_6_4_6_8 wdata,
  input  logic [AW-1:0]     raddr,
  output CGRAConfig_6_4_6_8 rdata
);

  CGRAConfig_6_4_6_8 mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_mem_sequencer.sv
// Per-tile control-memory sequencer: loads crossbar configs from the config
// bus and replays them into the crossbar recv_opt handshake N times (or forever).
module ctrl_mem_sequencer
  import cgra_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_cfg__en,
  input  CGRAConfig_6_4_6_8 recv_cfg__msg,
  output logic              recv_cfg__rdy,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] num_iter,
  output logic              send_opt__en,
  output CGRAConfig_6_4_6_8 send_opt__msg,
  input  logic              send_opt__rdy,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  seq_state_e        state;
  logic [AW:0]       wptr;
  logic [AW-1:0]     pc;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_max;
  logic              busy_q;
  logic              done_q;

  CGRAConfig_6_4_6_8 rd_word;
  logic              cfg_write;
  logic              xfer;
  logic              last_word;
  logic              last_pass;

  ctrl_mem_rf #(.DEPTH(DEPTH)) u_rf (
    .clk   (clk),
    .we    (cfg_write),
    .waddr (wptr[AW-1:0]),
    .wdata (recv_cfg__msg),
    .raddr (pc),
    .rdata (rd_word)
  );

  // Config loading is refused while start/clear are pending so a write can
  // never race a replay start or a memory clear.
  assign recv_cfg__rdy = (state == SEQ_IDLE) && !start && !clear && (wptr != FULL);
  assign cfg_write     = recv_cfg__en && recv_cfg__rdy;
  assign xfer          = (state == SEQ_RUN) && send_opt__rdy && !stop;
  assign last_word     = ({1'b0, pc} == (wptr - 1'b1));
  assign last_pass     = (iter_max != '0) && (iter == (iter_max - 1'b1));

  assign send_opt__en = xfer;
  assign busy         = busy_q;
  assign done         = done_q;

  // The crossbar samples msg regardless of en, so outside RUN it sees OPT_START.
  always_comb begin
    send_opt__msg      = '0;
    send_opt__msg.ctrl = OPT_START;
    if (state == SEQ_RUN) send_opt__msg = rd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEQ_IDLE;
      wptr     <= '0;
      pc       <= '0;
      iter     <= '0;
      iter_max <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (cfg_write) wptr <= wptr + 1'b1;
          if (clear) begin
            wptr <= '0;
          end else if (start && (wptr != '0)) begin
            state    <= SEQ_RUN;
            pc       <= '0;
            iter     <= '0;
            iter_max <= num_iter;
            busy_q   <= 1'b1;
          end
        end
        SEQ_RUN: begin
          if (stop) begin
            state  <= SEQ_IDLE;
            busy_q <= 1'b0;
          end else if (xfer) begin
            if (last_word) begin
              pc   <= '0;
              iter <= iter + 1'b1;
              if (last_pass) begin
                state  <= SEQ_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        SEQ_DONE: state <= SEQ_IDLE;
        default:  state <= SEQ_IDLE;
      endcase
    end
  end

endmodule
